ahb_slave_arbiter_param: RTL and testbench

AHB_SLAVE_ARBITER_PARAM -- requirements
Module: ahb_slave_arbiter_param

---
 rtl/ahb_slave_arbiter_param.sv | 194 +++++++++++++++++++
 tb/tb_ahb_slave_arbiter_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter_param.sv
// ============================================================================
//  Module      : ahb_slave_arbiter_param
//  Description : AHB slave-side arbiter. Grants one of MASTER_NUM requesters
//                (fixed priority or round robin), tracks the owner's burst
//                and pulses hlast on the accepted final beat.
//                Optional feature macro: AHB_ARB_LOCK_EN (adds hlock input,
//                locked owner keeps the grant at transaction end).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ahb_slave_arbiter_param #(
    parameter int MASTER_NUM = 4,
    parameter int ARB_MODE   = 1
) (
    input  logic                          hclk,
    input  logic                          hreset_n,
    input  logic [MASTER_NUM-1:0]         hreq,
    input  logic [2:0]                    hburst,
    input  logic [1:0]                    htrans,
    input  logic                          hwait,
`ifdef AHB_ARB_LOCK_EN
    input  logic [MASTER_NUM-1:0]         hlock,
`endif
    output logic [MASTER_NUM-1:0]         hgrant,
    output logic                          hsel,
    output logic [$clog2(MASTER_NUM)-1:0] hmaster,
    output logic                          hlast
);

    localparam int IDX_W = $clog2(MASTER_NUM);

    // AHB hburst encodings
    localparam logic [2:0] c_burst_single = 3'd0;
    localparam logic [2:0] c_burst_incr   = 3'd1;
    localparam logic [2:0] c_burst_wrap4  = 3'd2;
    localparam logic [2:0] c_burst_incr4  = 3'd3;
    localparam logic [2:0] c_burst_wrap8  = 3'd4;
    localparam logic [2:0] c_burst_incr8  = 3'd5;
    localparam logic [2:0] c_burst_wrap16 = 3'd6;
    localparam logic [2:0] c_burst_incr16 = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [MASTER_NUM-1:0]   grant_q, grant_d;
    logic [3:0]              cnt_q,   cnt_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]        w_owner_idx;
    logic                    w_owner_req;
    logic                    w_is_fixed;
    logic [3:0]              w_last_cnt;
    logic                    w_beat_acc;
    logic                    w_txn_end;
    logic                    w_keep;
    logic                    w_win_found;
    logic [IDX_W-1:0]        w_win_idx;
    logic [MASTER_NUM-1:0]   w_win_onehot;
    logic                    w_unused_ok;

    // htrans[0] only distinguishes NONSEQ from SEQ, which the arbiter ignores
    assign w_unused_ok = htrans[0];

    // Encode the one-hot grant into the owner index (0 when no owner)
    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (grant_q[i]) w_owner_idx = i[IDX_W-1:0];
        end
    end

    assign w_owner_req = |(hreq & grant_q);

    // Decode burst length; w_last_cnt is the counter value of the final beat
    always_comb begin
        w_is_fixed = 1'b1;
        w_last_cnt = 4'd0;
        case (hburst)
            c_burst_single:                 w_last_cnt = 4'd0;
            c_burst_incr:                   w_is_fixed = 1'b0;
            c_burst_wrap4,  c_burst_incr4:  w_last_cnt = 4'd3;
            c_burst_wrap8,  c_burst_incr8:  w_last_cnt = 4'd7;
            c_burst_wrap16, c_burst_incr16: w_last_cnt = 4'd15;
            default:                        w_last_cnt = 4'd0;
        endcase
    end

    assign w_beat_acc = (state_q == ST_BUSY) && htrans[1] && !hwait;

    // Fixed bursts end on their last counted beat and ignore hreq drops;
    // INCR ends on any non-stalled cycle in which the owner no longer requests
    assign w_txn_end = w_is_fixed ? (w_beat_acc && (cnt_q == w_last_cnt))
                                  : ((state_q == ST_BUSY) && !hwait && !w_owner_req);

    assign hlast = w_txn_end;

`ifdef AHB_ARB_LOCK_EN
    assign w_keep = hlock[w_owner_idx] && w_owner_req;
`else
    assign w_keep = 1'b0;
`endif

    // Select the winning requester (lowest index, or rotating from rr_ptr+1)
    always_comb begin : p_arbitrate
        int j;
        j           = 0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        if (ARB_MODE == 0) begin
            for (int i = MASTER_NUM - 1; i >= 0; i--) begin
                if (hreq[i]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = i[IDX_W-1:0];
                end
            end
        end else begin
            for (int k = 0; k < MASTER_NUM; k++) begin
                j = (int'(rr_ptr_q) + 1 + k) % MASTER_NUM;
                if (!w_win_found && hreq[j]) begin
                    w_win_found = 1'b1;
                    w_win_idx   = j[IDX_W-1:0];
                end
            end
        end
        w_win_onehot = {{(MASTER_NUM-1){1'b0}}, 1'b1} << w_win_idx;
    end

    // Next-state, grant, beat counter and round-robin pointer
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = 4'd0;
                grant_d = '0;
                if (w_win_found) begin
                    grant_d  = w_win_onehot;
                    rr_ptr_d = w_win_idx;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_txn_end) begin
                    cnt_d = 4'd0;
                    if (w_keep) begin
                        grant_d = grant_q;
                    end else if (w_win_found) begin
                        grant_d  = w_win_onehot;
                        rr_ptr_d = w_win_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (w_beat_acc) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State register; reset points RR at the last master so master 0 is first
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            cnt_q    <= 4'd0;
            rr_ptr_q <= IDX_W'(MASTER_NUM - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign hgrant  = grant_q & {MASTER_NUM{~hwait}};
    assign hsel    = |grant_q;
    assign hmaster = w_owner_idx;

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_arbiter_param.sv
// ============================================================================
//  Module      : tb_ahb_slave_arbiter_param
//  Description : Self-checking bench; a fixed-priority and a round-robin
//                instance share the same stimulus and are both checked.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_slave_arbiter_param;

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [1:0] ID     = 2'b00;
    localparam logic [1:0] NS     = 2'b10;
    localparam logic [1:0] SQ     = 2'b11;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic [3:0] hreq;
    logic [3:0] hlock;
    logic [2:0] hburst;
    logic [1:0] htrans;
    logic       hwait;

    logic [3:0] g_fx, g_rr;
    logic       sel_fx, sel_rr;
    logic [1:0] m_fx, m_rr;
    logic       last_fx, last_rr;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter_param #(.MASTER_NUM(4), .ARB_MODE(0)) u_fx (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
        .htrans(htrans), .hwait(hwait),
`ifdef AHB_ARB_LOCK_EN
        .hlock(hlock),
`endif
        .hgrant(g_fx), .hsel(sel_fx), .hmaster(m_fx), .hlast(last_fx)
    );

    ahb_slave_arbiter_param #(.MASTER_NUM(4), .ARB_MODE(1)) u_rr (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst),
        .htrans(htrans), .hwait(hwait),
`ifdef AHB_ARB_LOCK_EN
        .hlock(hlock),
`endif
        .hgrant(g_rr), .hsel(sel_rr), .hmaster(m_rr), .hlast(last_rr)
    );

    typedef struct {
        logic [3:0] hreq;
        logic [2:0] hburst;
        logic [1:0] htrans;
        logic       hwait;
        logic [3:0] own_fx;
        logic [3:0] own_rr;
        logic       last;
    } vec_t;

    typedef struct {
        logic [3:0] own_fx;
        logic [3:0] own_rr;
        logic       hwait;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   stepno = 0;
    vec_t tbl[16];

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL step %0d %s: got %h expected %h", stepno, name, act, exp);
        end
    endtask

    // One cycle: drive at falling edge, push expectation, compare 2ns later
    task automatic step(input logic rst, input logic [3:0] rq, input logic [2:0] hb,
                        input logic [1:0] ht, input logic hw,
                        input logic [3:0] ofx, input logic [3:0] orr, input logic lst);
        exp_t e;
        @(negedge hclk);
        hreset_n = ~rst;
        hreq     = rq;
        hburst   = hb;
        htrans   = ht;
        hwait    = hw;
        e.own_fx = ofx;
        e.own_rr = orr;
        e.hwait  = hw;
        e.last   = lst;
        sbq.push_back(e);
        #2;
        e = sbq.pop_front();
        chk("fx_hgrant",  g_fx, e.own_fx & ~{4{e.hwait}});
        chk("fx_hsel",    {3'b0, sel_fx},  {3'b0, |e.own_fx});
        chk("fx_hmaster", {2'b0, m_fx},    {2'b0, enc(e.own_fx)});
        chk("fx_hlast",   {3'b0, last_fx}, {3'b0, e.last});
        chk("rr_hgrant",  g_rr, e.own_rr & ~{4{e.hwait}});
        chk("rr_hsel",    {3'b0, sel_rr},  {3'b0, |e.own_rr});
        chk("rr_hmaster", {2'b0, m_rr},    {2'b0, enc(e.own_rr)});
        chk("rr_hlast",   {3'b0, last_rr}, {3'b0, e.last});
        stepno++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        hreq     burst   trans wait own_fx   own_rr   last
        tbl[0]  = '{4'b1010, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1010, SINGLE, NS, 1'b0, 4'b0010, 4'b0010, 1'b1};
        tbl[2]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0010, 4'b1000, 1'b1};
        tbl[3]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b0001, 1'b1};
        tbl[4]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b0010, 1'b1};
        tbl[5]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b0100, 1'b1};
        tbl[6]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b1000, 1'b1};
        tbl[7]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b0001, 1'b1};
        tbl[8]  = '{4'b1111, SINGLE, NS, 1'b1, 4'b0001, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1111, SINGLE, NS, 1'b0, 4'b0001, 4'b0010, 1'b1};
        tbl[10] = '{4'b0000, SINGLE, ID, 1'b0, 4'b0001, 4'b0100, 1'b0};
        tbl[11] = '{4'b0000, SINGLE, NS, 1'b0, 4'b0001, 4'b0100, 1'b1};
        tbl[12] = '{4'b1000, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{4'b1000, SINGLE, NS, 1'b0, 4'b1000, 4'b1000, 1'b1};
        tbl[14] = '{4'b0000, SINGLE, NS, 1'b0, 4'b1000, 4'b1000, 1'b1};
        tbl[15] = '{4'b0000, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0};

        hreset_n = 1'b0;
        hreq     = 4'b0;
        hlock    = 4'b0;
        hburst   = SINGLE;
        htrans   = ID;
        hwait    = 1'b0;

        // Reset state, with requests present to show they are ignored
        step(1'b1, 4'b0000, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, SINGLE, NS, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Arbitration order, SINGLE transfers, wait masking
        for (int i = 0; i < 16; i++)
            step(1'b0, tbl[i].hreq, tbl[i].hburst, tbl[i].htrans, tbl[i].hwait,
                 tbl[i].own_fx, tbl[i].own_rr, tbl[i].last);

        // INCR8 by master 2, 3 wait cycles on beat 4, hreq dropped from beat 6
        step(1'b0, 4'b0100, INCR8, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, INCR8, NS, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0100, INCR8, SQ, 1'b1, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, INCR8, SQ, 1'b0, 4'b0100, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, INCR8, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // INCR by master 0 ends on beat 5 with hreq drop; master 1 then ends on idle
        step(1'b0, 4'b0011, INCR, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0011, INCR, NS, 1'b0, 4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0011, INCR, SQ, 1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0010, INCR, SQ, 1'b0, 4'b0001, 4'b0001, 1'b1);
        step(1'b0, 4'b0010, INCR, ID, 1'b0, 4'b0010, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, INCR, ID, 1'b0, 4'b0010, 4'b0010, 1'b1);
        step(1'b0, 4'b0000, INCR, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset on beat 2 of WRAP4, then fresh grant one cycle after request
        step(1'b0, 4'b0001, WRAP4, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, WRAP4, NS, 1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b1, 4'b0001, WRAP4, SQ, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0001, WRAP4, SQ, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, SINGLE, ID, 1'b0, 4'b0001, 4'b0001, 1'b0);

        // Complete WRAP4: hlast exactly on the 4th beat despite hreq drop
        step(1'b0, 4'b0001, WRAP4, NS, 1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, WRAP4, SQ, 1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, WRAP4, SQ, 1'b0, 4'b0001, 4'b0001, 1'b0);
        step(1'b0, 4'b0000, WRAP4, SQ, 1'b0, 4'b0001, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, WRAP4, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);

`ifdef AHB_ARB_LOCK_EN
        // Locked master 3 keeps the grant, moves to master 0 once unlocked
        step(1'b1, 4'b0000, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        hlock = 4'b1000;
        step(1'b0, 4'b1000, SINGLE, ID, 1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b1111, SINGLE, NS, 1'b0, 4'b1000, 4'b1000, 1'b1);
        hlock = 4'b0000;
        step(1'b0, 4'b1111, SINGLE, NS, 1'b0, 4'b1000, 4'b1000, 1'b1);
        step(1'b0, 4'b1111, SINGLE, ID, 1'b0, 4'b0001, 4'b0001, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
